// File: rtl/tvm_mmap_pkg.sv
// Shared types for the virtual-DRAM mmap controllers.
package tvm_mmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tvm_mmap_addr_gen.sv
// Loadable offset counter: wraps modulo 2^ADDR_WIDTH, flags the final word of a run.
module tvm_mmap_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_off,
  input  logic [LEN_WIDTH-1:0]  load_cnt,
  output logic [ADDR_WIDTH-1:0] off,
  output logic                  last_c
);

  logic [LEN_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      off <= '0;
      cnt <= '0;
    end else if (load) begin
      off <= load_off;
      cnt <= load_cnt;
    end else if (step) begin
      off <= off + ADDR_WIDTH'(1);
      cnt <= cnt - LEN_WIDTH'(1);
    end
  end

  assign last_c = (cnt == LEN_WIDTH'(1));

endmodule

// File: rtl/tvm_vpi_mmap_copy_ctrl.sv
// Copies a block of words from a read mmap to a write mmap, one word per cycle.
// Define TVM_MMAP_COPY_CKSUM_EN to build the running checksum of written words.
module tvm_vpi_mmap_copy_ctrl
  import tvm_mmap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned BASE_ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH       = ADDR_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [BASE_ADDR_WIDTH-1:0] cmd_src_base,
  input  logic [BASE_ADDR_WIDTH-1:0] cmd_dst_base,
  input  logic [ADDR_WIDTH-1:0]      cmd_src_off,
  input  logic [ADDR_WIDTH-1:0]      cmd_dst_off,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [DATA_WIDTH-1:0]      cksum,
  output logic [BASE_ADDR_WIDTH-1:0] rd_mmap_addr,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic [BASE_ADDR_WIDTH-1:0] wr_mmap_addr,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_en
);

  state_e state, state_next;
  logic   accept_c, load_c, src_step_c, src_last_c, dst_last_c;
  logic   wr_en_next, aborted_next;

  // A zero-length command skips the counters so rd_addr stays put.
  assign load_c = accept_c && (cmd_len != '0);

  tvm_mmap_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_src_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .step     (src_step_c),
    .load_off (cmd_src_off),
    .load_cnt (cmd_len),
    .off      (rd_addr),
    .last_c   (src_last_c)
  );

  // Destination counter advances on each write; its terminal flag marks the drain write.
  tvm_mmap_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_dst_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .step     (wr_en),
    .load_off (cmd_dst_off),
    .load_cnt (cmd_len),
    .off      (wr_addr),
    .last_c   (dst_last_c)
  );

  always_comb begin
    state_next   = state;
    accept_c     = 1'b0;
    src_step_c   = 1'b0;
    wr_en_next   = 1'b0;
    aborted_next = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c   = 1'b1;
          state_next = (cmd_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort drops the read issued this cycle: no write follows it.
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = DONE;
        end else begin
          wr_en_next = 1'b1;
          if (src_last_c) state_next = DRAIN;
          else            src_step_c = 1'b1;
        end
      end
      DRAIN: begin
        if (dst_last_c) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      wr_en        <= 1'b0;
      rd_mmap_addr <= '0;
      wr_mmap_addr <= '0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      aborted   <= aborted_next;
      wr_en     <= wr_en_next;
      if (accept_c) begin
        rd_mmap_addr <= cmd_src_base;
        wr_mmap_addr <= cmd_dst_base;
      end
    end
  end

  assign wr_data = rd_data;

`ifdef TVM_MMAP_COPY_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept_c) cksum <= '0;
    else if (wr_en)      cksum <= cksum + rd_data;
  end
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_tvm_vpi_mmap_copy_ctrl.sv
// Scoreboard bench for tvm_vpi_mmap_copy_ctrl with a behavioural read-memory model.
module tb_tvm_vpi_mmap_copy_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 32;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [BW-1:0] cmd_src_base = '0, cmd_dst_base = '0;
  logic [AW-1:0] cmd_src_off = '0, cmd_dst_off = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy, done, aborted;
  logic [DW-1:0] cksum;
  logic [BW-1:0] rd_mmap_addr, wr_mmap_addr;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, wr_data;
  logic          wr_en;

  tvm_vpi_mmap_copy_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
    .cmd_src_off(cmd_src_off), .cmd_dst_off(cmd_dst_off), .cmd_len(cmd_len),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted), .cksum(cksum),
    .rd_mmap_addr(rd_mmap_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_mmap_addr(wr_mmap_addr), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source region: registered read, data one cycle after the address.
  logic [DW-1:0] mem [256];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    int unsigned   cyc;
    logic [BW-1:0] base;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;
  typedef struct {
    int unsigned   cyc;
    logic          ab;
    logic [DW-1:0] sum;
  } done_t;

  xfer_t rd_q[$];
  xfer_t wr_q[$];
  done_t dn_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares DUT activity against the queued expectations.
  always @(negedge clk) begin
    xfer_t x;
    done_t d;
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      x = rd_q.pop_front();
      check("rd_addr", rd_addr, x.addr);
      check("rd_mmap_addr", rd_mmap_addr, x.base);
    end
    if (wr_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", wr_en, 0);
      else begin
        x = wr_q.pop_front();
        check("wr_cycle", cyc, x.cyc);
        check("wr_addr", wr_addr, x.addr);
        check("wr_data", wr_data, x.data);
        check("wr_mmap_addr", wr_mmap_addr, x.base);
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      check("wr_missing", wr_en, 1);
      void'(wr_q.pop_front());
    end
    if (done) begin
      if (dn_q.size() == 0) check("done_unexpected", done, 0);
      else begin
        d = dn_q.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("aborted", aborted, d.ab);
        check("cksum", cksum, d.sum);
      end
    end else if (dn_q.size() > 0 && dn_q[0].cyc <= cyc) begin
      check("done_missing", done, 1);
      void'(dn_q.pop_front());
    end
  end

  // Issue one command and drive it to completion (or to an abort / mid-run reset).
  task automatic do_cmd(input logic [BW-1:0] sb, input logic [BW-1:0] db,
                        input logic [AW-1:0] so, input logic [AW-1:0] dof,
                        input int unsigned len, input int unsigned ab_at,
                        input bit hold, input int unsigned rst_at);
    int unsigned guard = 0;
    int unsigned base, nr, nw, dcyc, last;
    logic [DW-1:0] sum = '0;
    logic [AW-1:0] a;
    xfer_t x;
    done_t d;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_src_base = sb; cmd_dst_base = db;
    cmd_src_off = so; cmd_dst_off = dof; cmd_len = LW'(len);
    @(posedge clk); #1;
    base = cyc;
    if (hold) begin
      cmd_src_base = $urandom; cmd_dst_base = $urandom;
      cmd_src_off = AW'($urandom); cmd_dst_off = AW'($urandom);
      cmd_len = LW'($urandom_range(1, 9));
    end else cmd_valid = 1'b0;
    if (ab_at > 0)       begin nr = ab_at;  nw = ab_at - 1;  end
    else if (rst_at > 0) begin nr = rst_at; nw = rst_at - 1; end
    else                 begin nr = len;    nw = len;        end
    for (int unsigned k = 0; k < nr; k++) begin
      x.cyc = base + k; x.base = sb; x.addr = so + AW'(k); x.data = '0;
      rd_q.push_back(x);
    end
    for (int unsigned k = 0; k < nw; k++) begin
      a = so + AW'(k);
      x.cyc = base + 1 + k; x.base = db; x.addr = dof + AW'(k); x.data = mem[a];
      sum = sum + mem[a];
      wr_q.push_back(x);
    end
    dcyc = (len == 0) ? 1 : (ab_at > 0) ? ab_at + 1 : len + 2;
    if (rst_at == 0) begin
      d.cyc = base + dcyc - 1;
      d.ab  = (ab_at > 0);
`ifdef TVM_MMAP_COPY_CKSUM_EN
      d.sum = sum;
`else
      d.sum = '0;
`endif
      dn_q.push_back(d);
    end
    last = (rst_at > 0) ? rst_at : dcyc;
    for (int unsigned c = 1; c <= last; c++) begin
      abort = (c == ab_at);
      if (c == rst_at) rst = 1'b1;
      if (hold && c == last) cmd_valid = 1'b0;
      check("busy_run", busy, 1);
      check("cmd_ready_run", cmd_ready, 0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    if (rst_at > 0) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_wr_mmap_addr", wr_mmap_addr, 0);
      check("rst_cksum", cksum, 0);
      rst = 1'b0;
      @(posedge clk); #1;
    end
    check("busy_idle", busy, 0);
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len, ab;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_aborted", aborted, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_rd_mmap_addr", rd_mmap_addr, 0);
    check("reset_cksum", cksum, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", cmd_ready, 1);

    do_cmd(32'h1000_0000, 32'h2000_0000, 8'h10, 8'h80, 4, 0, 1'b0, 0);
    do_cmd(32'h1111_0000, 32'h2222_0000, 8'hFE, 8'h40, 4, 0, 1'b0, 0);
    do_cmd(32'h3000_0000, 32'h4000_0000, 8'h20, 8'h30, 0, 0, 1'b0, 0);
    do_cmd(32'h5000_0000, 32'h6000_0000, 8'h10, 8'hF0, 8, 4, 1'b0, 0);
    do_cmd(32'h7000_0000, 32'h8000_0000, 8'h05, 8'hFD, 6, 0, 1'b1, 0);
    do_cmd(32'h9000_0000, 32'hA000_0000, 8'h60, 8'h70, 3, 0, 1'b0, 0);
    do_cmd(32'hB000_0000, 32'hC000_0000, 8'h00, 8'h10, 10, 0, 1'b1, 4);
    do_cmd(32'hD000_0000, 32'hE000_0000, 8'h33, 8'h00, 256, 0, 1'b0, 0);
    do_cmd(32'h0BAD_0000, 32'h0000_BEEF, 8'h80, 8'h81, 5, 1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(0, 20);
      ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      do_cmd($urandom, $urandom, AW'($urandom), AW'($urandom), len, ab,
             1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", dn_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
